// File: rtl/uart_core.sv
// Minimal 8N1 UART: shared 8x baud prescaler, inverted-polarity transmitter, 8x-oversampled receiver.
// Optional `UART_FRAMEERR_EN adds a rxframeerr pulse output and stop-bit checking.
module uart_core #(
  parameter int CLKDIV            = 16,
  parameter bit HASRXBYTEREGISTER = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cte1,
  input  logic       load,
  input  logic [7:0] d,
  input  logic       rxpin,
  output logic       txpin,
  output logic       txbusy,
  output logic       bitx8ce,
  output logic       bytercvd,
  output logic [7:0] q
`ifdef UART_FRAMEERR_EN
  ,
  output logic       rxframeerr
`endif
);

  localparam int PW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  // ---------------- prescaler ----------------
  logic [PW-1:0] pre_cnt_reg;
  logic          bitx8ce_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_reg <= '0;
      bitx8ce_reg <= 1'b0;
    end else begin
      bitx8ce_reg <= 1'b0;
      if (cte1) begin
        if (pre_cnt_reg == PW'(CLKDIV - 1)) begin
          pre_cnt_reg <= '0;
          bitx8ce_reg <= 1'b1;
        end else begin
          pre_cnt_reg <= pre_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign bitx8ce = bitx8ce_reg;

  // ---------------- transmitter ----------------
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  tx_state_t  tx_state_reg, tx_state_next;
  logic [9:0] tx_frame_reg;
  logic [2:0] tx_tick_reg;
  logic [3:0] tx_idx_reg;
  logic       tx_start, tx_shift_en;

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_start      = 1'b0;
    tx_shift_en   = 1'b0;
    case (tx_state_reg)
      TX_IDLE: begin
        if (load) begin
          tx_start      = 1'b1;
          tx_state_next = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (bitx8ce_reg && tx_tick_reg == 3'd7) begin
          tx_shift_en = 1'b1;
          if (tx_idx_reg == 4'd9) tx_state_next = TX_IDLE;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // Frame is {stop, data, start}; bit 0 is always the bit currently on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg <= TX_IDLE;
      tx_frame_reg <= '0;
      tx_tick_reg  <= '0;
      tx_idx_reg   <= '0;
    end else begin
      tx_state_reg <= tx_state_next;
      if (tx_start) begin
        tx_frame_reg <= {1'b1, d, 1'b0};
        tx_tick_reg  <= '0;
        tx_idx_reg   <= '0;
      end else if (tx_state_reg == TX_BUSY && bitx8ce_reg) begin
        tx_tick_reg <= tx_tick_reg + 1'b1;
        if (tx_shift_en) begin
          tx_frame_reg <= {1'b1, tx_frame_reg[9:1]};
          tx_idx_reg   <= tx_idx_reg + 1'b1;
        end
      end
    end
  end

  assign txbusy = (tx_state_reg == TX_BUSY);
  assign txpin  = txbusy ? ~tx_frame_reg[0] : 1'b0;

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t  rx_state_reg, rx_state_next;
  logic [1:0] rx_sync_reg;
  logic [7:0] rx_shift_reg;
  logic [2:0] rx_cnt_reg;
  logic [2:0] rx_bit_reg;
  logic       rx_s, rx_cnt_clr, rx_sample, rx_stop, rx_good;
  logic       bytercvd_reg;

  assign rx_s = rx_sync_reg[1];

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_clr    = 1'b0;
    rx_sample     = 1'b0;
    rx_stop       = 1'b0;
    if (bitx8ce_reg) begin
      case (rx_state_reg)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_cnt_clr    = 1'b1;
            rx_state_next = RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_reg == 3'd3) begin
            rx_cnt_clr    = 1'b1;
            rx_state_next = rx_s ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == 3'd7) begin
            rx_sample = 1'b1;
            if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_cnt_reg == 3'd7) begin
            rx_stop       = 1'b1;
            rx_state_next = RX_IDLE;
          end
        end
        default: rx_state_next = RX_IDLE;
      endcase
    end
  end

`ifdef UART_FRAMEERR_EN
  assign rx_good = rx_stop & rx_s;
`else
  assign rx_good = rx_stop;
`endif

  // Synchronizer resets to the idle level so release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_reg <= RX_IDLE;
      rx_sync_reg  <= 2'b11;
      rx_shift_reg <= '0;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      bytercvd_reg <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_sync_reg  <= {rx_sync_reg[0], rxpin};
      bytercvd_reg <= rx_good;
      if (rx_cnt_clr) begin
        rx_cnt_reg <= '0;
        rx_bit_reg <= '0;
      end else if (bitx8ce_reg) begin
        rx_cnt_reg <= rx_cnt_reg + 1'b1;
      end
      if (rx_sample) begin
        rx_shift_reg <= {rx_s, rx_shift_reg[7:1]};
        rx_bit_reg   <= rx_bit_reg + 1'b1;
      end
    end
  end

  assign bytercvd = bytercvd_reg;

`ifdef UART_FRAMEERR_EN
  logic rxframeerr_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rxframeerr_reg <= 1'b0;
    else        rxframeerr_reg <= rx_stop & ~rx_s;
  end
  assign rxframeerr = rxframeerr_reg;
`endif

  generate
    if (HASRXBYTEREGISTER) begin : g_qreg
      logic [7:0] q_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       q_reg <= '0;
        else if (rx_good) q_reg <= rx_shift_reg;
      end
      assign q = q_reg;
    end else begin : g_qlive
      assign q = rx_shift_reg;
    end
  endgenerate

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: loopback, ignored load, prescaler pause, RX glitch and mid-frame reset.
module tb_uart_core;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cte1 = 1'b1;
  logic       load = 1'b0;
  logic [7:0] d = 8'h00;
  logic       rx_force_en = 1'b0;
  logic       rx_force_val = 1'b1;
  logic       rxpin;
  logic       txpin, txbusy, bitx8ce, bytercvd;
  logic [7:0] q;
`ifdef UART_FRAMEERR_EN
  logic       rxframeerr;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  assign rxpin = rx_force_en ? rx_force_val : ~txpin;

  uart_core #(.CLKDIV(16), .HASRXBYTEREGISTER(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cte1(cte1), .load(load), .d(d), .rxpin(rxpin),
    .txpin(txpin), .txbusy(txbusy), .bitx8ce(bitx8ce), .bytercvd(bytercvd), .q(q)
`ifdef UART_FRAMEERR_EN
    , .rxframeerr(rxframeerr)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("vector %0d %s: observed %0h expected %0h", vectors, tag, obs, exp);
  endtask

  // Returns cycles waited until bytercvd is seen, or -1 if the budget expires.
  task automatic wait_rcvd(input int budget, output int lat);
    int n;
    n = 0;
    lat = -1;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (bytercvd) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (txbusy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("tx_idle", {31'd0, txbusy}, 32'd0);
  endtask

  task automatic pulse_load(input logic [7:0] b);
    @(negedge clk);
    d = b;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int lat, cnt, chg, n;
    logic t0;
    logic [7:0] b;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txpin", {31'd0, txpin}, 32'd0);
    check("rst_txbusy", {31'd0, txbusy}, 32'd0);
    check("rst_bitx8ce", {31'd0, bitx8ce}, 32'd0);
    check("rst_bytercvd", {31'd0, bytercvd}, 32'd0);
    check("rst_q", {24'd0, q}, 32'd0);
    rst_n = 1'b1;

    // Prescaler period
    n = 0;
    while (!bitx8ce && n < 40) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!bitx8ce && n < 40);
    check("bitx8ce_period", n, 32'd16);

    // Loopback 0x41 at cycle 333
    while (cyc < 333) @(negedge clk);
    d = 8'h41;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("lb1_txbusy_rise", {31'd0, txbusy}, 32'd1);
    check("lb1_start_bit", {31'd0, txpin}, 32'd1);
    wait_rcvd(1500, lat);
    check("lb1_latency_in_range", {31'd0, (lat + 1 >= 1200) && (lat + 1 <= 1300)}, 32'd1);
    check("lb1_q", {24'd0, q}, 32'h41);
    @(negedge clk);
    check("lb1_pulse_one_cycle", {31'd0, bytercvd}, 32'd0);
    repeat (50) @(negedge clk);
    check("lb1_q_hold", {24'd0, q}, 32'h41);

    // Second byte 0x4E at cycle 1640
    wait_idle(400);
    while (cyc < 1640) @(negedge clk);
    d = 8'h4E;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_rcvd(1400, lat);
    check("lb2_before_3000", {31'd0, (lat >= 0) && (cyc < 3000)}, 32'd1);
    check("lb2_q", {24'd0, q}, 32'h4E);

    // Load while busy is ignored
    wait_idle(400);
    pulse_load(8'hA3);
    repeat (100) @(negedge clk);
    pulse_load(8'hFF);
    cnt = 0;
    repeat (1500) begin
      @(negedge clk);
      if (bytercvd) cnt++;
    end
    check("busy_load_pulses", cnt, 32'd1);
    check("busy_load_q", {24'd0, q}, 32'hA3);
    check("busy_load_idle_after", {31'd0, txbusy}, 32'd0);

    // Prescaler pause mid-frame
    pulse_load(8'h3C);
    repeat (400) @(negedge clk);
    cte1 = 1'b0;
    @(negedge clk);
    t0 = txpin;
    cnt = 0;
    chg = 0;
    repeat (500) begin
      @(negedge clk);
      if (bitx8ce) cnt++;
      if (txpin !== t0) chg++;
    end
    check("pause_no_ticks", cnt, 32'd0);
    check("pause_txpin_frozen", chg, 32'd0);
    check("pause_still_busy", {31'd0, txbusy}, 32'd1);
    cte1 = 1'b1;
    wait_rcvd(1500, lat);
    check("pause_rcvd", {31'd0, lat >= 0}, 32'd1);
    check("pause_q", {24'd0, q}, 32'h3C);

    // RX glitch of 2 ticks, then bit-banged 0x55
    wait_idle(400);
    rx_force_val = 1'b1;
    rx_force_en = 1'b1;
    repeat (40) @(negedge clk);
    n = 0;
    while (!bitx8ce && n < 40) begin @(negedge clk); n++; end
    rx_force_val = 1'b0;
    repeat (32) @(negedge clk);
    rx_force_val = 1'b1;
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (bytercvd) cnt++;
    end
    check("glitch_no_byte", cnt, 32'd0);
    b = 8'h55;
    rx_force_val = 1'b0;
    repeat (128) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_force_val = b[i];
      repeat (128) @(negedge clk);
    end
    rx_force_val = 1'b1;
    wait_rcvd(300, lat);
    check("glitch_rearm_rcvd", {31'd0, lat >= 0}, 32'd1);
    check("glitch_rearm_q", {24'd0, q}, 32'h55);
    repeat (200) @(negedge clk);
    rx_force_en = 1'b0;

    // Reset mid-frame
    repeat (20) @(negedge clk);
    pulse_load(8'h77);
    repeat (300) @(negedge clk);
    check("pre_rst_busy", {31'd0, txbusy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_txpin", {31'd0, txpin}, 32'd0);
    check("midrst_txbusy", {31'd0, txbusy}, 32'd0);
    check("midrst_q", {24'd0, q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    pulse_load(8'hA5);
    wait_rcvd(1500, lat);
    check("postrst_rcvd", {31'd0, lat >= 0}, 32'd1);
    check("postrst_q", {24'd0, q}, 32'hA5);
    wait_idle(400);
    check("postrst_txpin_idle", {31'd0, txpin}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Minimal 8N1 UART for iCE40-class FPGAs: one transmitter, one receiver, one shared baud prescaler.
- Prescaler produces an 8x-oversampling enable, `bitx8ce`; each serial bit lasts 8 `bitx8ce` ticks.
- The TX output is driven logically inverted because the pad stage re-inverts it. RX input is true polarity.
- Sits between a host byte interface (`load`/`d`, `bytercvd`/`q`) and the serial pins.

Parameters:
- CLKDIV, default 16: clocks between `bitx8ce` pulses, counted while `cte1`=1. Bit time = 8*CLKDIV clocks, i.e. 128 by default.
- HASRXBYTEREGISTER, default 1: when 1, `q` is a holding register; when 0, `q` is the live RX shift register.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- cte1  in  1  global clock enable for the prescaler; tie high for free-running operation
- load  in  1  one-cycle request to transmit `d`
- d  in  8  byte to transmit, sampled in the cycle `load`=1
- rxpin  in  1  serial input, true polarity, idle high
- txpin  out  1  serial output, inverted polarity, idle low
- txbusy  out  1  high while a frame is in progress
- bitx8ce  out  1  one-cycle pulse at 8x the baud rate
- bytercvd  out  1  one-cycle pulse when a byte is complete
- q  out  8  received byte

Behaviour:
- Reset (`rst_n`=0, async):
  - all counters and shift registers cleared
  - `txpin`=0 (line idle), `txbusy`=0, `bitx8ce`=0, `bytercvd`=0, `q`=8'h00
- Prescaler:
  - counter 0..CLKDIV-1, increments only when `cte1`=1
  - `bitx8ce`=1 for exactly one clock each time the counter wraps; never asserts while `cte1`=0
- Transmit:
  - `load`=1 with `txbusy`=0: capture `d` and set `txbusy`=1 on the next edge.
  - `load` while `txbusy`=1 is ignored; there is no queue.
  - Frame on the true line: start bit 0, d[0]..d[7] LSB first, stop bit 1.
  - `txpin` carries the complement of the true line.
  - Each bit holds for 8 `bitx8ce` ticks. The start bit begins at capture, so its first period may be up to one tick short.
  - `txbusy` drops after the 8th tick of the stop bit, about 80 ticks after capture.
  - A new `load` is accepted in that same cycle.
- Receive (8x oversampling):
  - `rxpin` passes through a 2-flop synchronizer.
  - Idle until a 0 is sampled on a `bitx8ce` tick.
  - Re-sample 4 ticks later, mid-start-bit. If it is 1, treat as a glitch and return to idle.
  - Otherwise take 8 data samples, 8 ticks apart, shifting LSB first, then sample the stop bit 8 ticks later.
  - At the stop sample, pulse `bytercvd` for one clock and return to idle; receiver hunts for a new start edge from then on.
- Received data (`q`):
  - HASRXBYTEREGISTER=1: `q` loads the assembled byte on the `bytercvd` edge and holds until the next byte.
  - HASRXBYTEREGISTER=0: `q` is the shift register; valid during and the cycle after the `bytercvd` pulse.
- TX and RX are fully independent; simultaneous activity is allowed.
- Reset mid-frame aborts both directions immediately; `txpin` returns to 0.

Optional Feature:
- Macro UART_FRAMEERR_EN.
- Defined:
  - adds output port `rxframeerr` (1 bit, reset 0)
  - a stop sample of 0 pulses `rxframeerr` for one clock and suppresses `bytercvd`
  - `q` is left unchanged
- Undefined:
  - no extra port
  - stop bit not checked; `bytercvd` pulses regardless of its value

Test Plan:
- Loopback with `rxpin` = ~`txpin`, `cte1`=1, CLKDIV=16, HASRXBYTEREGISTER=1, `load` pulse with `d`=8'h41 at cycle 333:
  - `txbusy` rises next cycle
  - `bytercvd` pulses roughly 1200–1300 cycles later
  - `q`=8'h41 and holds
- Same loopback, then `load` with `d`=8'h4E at cycle 1640 (after `txbusy` drops): second `bytercvd` gives `q`=8'h4E before cycle 3000.
- `load` with 8'hFF while `txbusy`=1 → ignored; the current frame completes unchanged and only one `bytercvd` pulse occurs.
- `cte1`=0 for 500 cycles mid-frame → no `bitx8ce` pulses and `txpin` frozen; the frame resumes correctly when `cte1` returns to 1.
- Drive `rxpin` low for 2 ticks only → no `bytercvd`; the receiver re-arms and then decodes a following valid 8'h55 frame.
- Assert `rst_n`=0 mid-frame → `txpin`=0, `txbusy`=0, `q`=0 immediately; a fresh `load` of 8'hA5 after release loops back correctly.
